// File: rtl/seq_arb_ctrl_if.sv
// Host-side bundle for the arbitrary-sequence controller.
// master: host/test logic drives the commands and table writes and reads back status.
// slave : the controller receives the commands and presents code/status.
//   cmd_run/cmd_stop/cmd_step : sequencing commands (stop > run > step)
//   oneshot                   : stop after one full lap (sampled at the wrap edge)
//   wr_en/wr_addr/wr_data     : code table write port
//   Q/idx                     : current code and table position
//   busy/wrap/laps/err        : run flag, wrap pulse, saturating lap count, sticky write error
interface seq_arb_ctrl_if #(
  parameter int W  = 4,
  parameter int N  = 8,
  parameter int LW = 8
);
  localparam int AW = $clog2(N);

  logic          cmd_run;
  logic          cmd_stop;
  logic          cmd_step;
  logic          oneshot;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  Q;
  logic [AW-1:0] idx;
  logic          busy;
  logic          wrap;
  logic [LW-1:0] laps;
  logic          err;

  modport master (
    output cmd_run, cmd_stop, cmd_step, oneshot, wr_en, wr_addr, wr_data,
    input  Q, idx, busy, wrap, laps, err
  );

  modport slave (
    input  cmd_run, cmd_stop, cmd_step, oneshot, wr_en, wr_addr, wr_data,
    output Q, idx, busy, wrap, laps, err
  );
endinterface

// File: rtl/seq_arb_ctrl.sv
// Sequencer for the arbitrary-sequence counter: walks a programmable N-entry
// code table under run/stop/step commands, continuous or one-shot.
// Ports:
//   C   : clock, rising edge
//   R   : synchronous active-high reset (restores the default table too)
//   bus : seq_arb_ctrl_if.slave - commands, table write port, code/status outputs
module seq_arb_ctrl #(
  parameter int W  = 4,
  parameter int N  = 8,
  parameter int LW = 8
) (
  input logic         C,
  input logic         R,
  seq_arb_ctrl_if.slave bus
);
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  tbl [N];
  logic [AW-1:0] idx;
  logic [LW-1:0] laps;
  logic          wrap;
  logic          err;
  logic          adv;
  logic          abort;
  logic          at_end;
  logic          wrap_edge;

  // Default sequence 4-5-14-3-6-12-11-13, repeated if the table is deeper.
  function automatic logic [W-1:0] dflt_code(input int i);
    logic [W-1:0] c;
    case (i % 8)
      0:       c = W'(4);
      1:       c = W'(5);
      2:       c = W'(14);
      3:       c = W'(3);
      4:       c = W'(6);
      5:       c = W'(12);
      6:       c = W'(11);
      default: c = W'(13);
    endcase
    return c;
  endfunction

  // Lap counter holds at all-ones instead of rolling over.
  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (&v) ? v : v + LW'(1);
  endfunction

  assign at_end    = (idx == AW'(N - 1));
  assign wrap_edge = adv && at_end;

  always_ff @(posedge C) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  // Next state; stop outranks run, which outranks step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.cmd_stop && bus.cmd_run) state_nxt = RUN;
      RUN:     if (bus.cmd_stop)                 state_nxt = PAUSE;
               else if (at_end && bus.oneshot)   state_nxt = IDLE;
      PAUSE:   if (bus.cmd_stop)                 state_nxt = IDLE;
               else if (bus.cmd_run)             state_nxt = RUN;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Entering RUN does not advance; the first advance is on the following edge.
  always_comb begin
    adv   = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE:    adv = !bus.cmd_stop && !bus.cmd_run && bus.cmd_step;
      RUN:     adv = !bus.cmd_stop;
      PAUSE: begin
        abort = bus.cmd_stop;
        adv   = !bus.cmd_stop && !bus.cmd_run && bus.cmd_step;
      end
      default: adv = 1'b0;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      idx  <= '0;
      laps <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
      for (int i = 0; i < N; i++) tbl[i] <= dflt_code(i);
    end else begin
      wrap <= wrap_edge;
      if (abort)    idx <= '0;
      else if (adv) idx <= at_end ? '0 : idx + AW'(1);
      if (wrap_edge) laps <= sat_inc(laps);
      // The table is frozen while running; an attempted write only flags err.
      if (bus.wr_en) begin
        if (state == RUN) err <= 1'b1;
        else              tbl[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Q reads straight from the table so writes and advances show with no extra delay.
  assign bus.Q    = tbl[idx];
  assign bus.idx  = idx;
  assign bus.busy = (state == RUN);
  assign bus.wrap = wrap;
  assign bus.laps = laps;
  assign bus.err  = err;
endmodule

// File: tb/tb_seq_arb_ctrl.sv
module tb_seq_arb_ctrl;
  logic C = 1'b0;
  logic R;

  always #5 C = ~C;

  seq_arb_ctrl_if #(.W(4), .N(8), .LW(8)) bus ();
  seq_arb_ctrl #(.W(4), .N(8), .LW(8)) dut (.C(C), .R(R), .bus(bus));

  typedef struct {
    int q;
    int idx;
    int busy;
    int wrap;
    int laps;
    int err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: table contents, position, mode (0 idle, 1 running, 2 paused).
  int m_tbl[8];
  int m_idx, m_laps, m_mode, m_wrap, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit run, input bit stop, input bit stp,
                       input bit os, input bit we, input int wa, input int wd);
    bit   adv;
    exp_t e;
    if (rst) begin
      m_tbl  = '{4, 5, 14, 3, 6, 12, 11, 13};
      m_idx  = 0; m_laps = 0; m_mode = 0; m_wrap = 0; m_err = 0;
    end else begin
      if (we) begin
        if (m_mode == 1) m_err = 1;
        else             m_tbl[wa] = wd;
      end
      adv    = 0;
      m_wrap = 0;
      if (m_mode == 0) begin
        if (!stop && run)       m_mode = 1;
        else if (!stop && stp)  adv = 1;
      end else if (m_mode == 1) begin
        if (stop) m_mode = 2;
        else      adv = 1;
      end else begin
        if (stop)      begin m_mode = 0; m_idx = 0; end
        else if (run)  m_mode = 1;
        else if (stp)  adv = 1;
      end
      if (adv) begin
        m_idx = m_idx + 1;
        if (m_idx == 8) begin
          m_idx  = 0;
          m_wrap = 1;
          if (m_laps < 255) m_laps = m_laps + 1;
          if (m_mode == 1 && os) m_mode = 0;
        end
      end
    end
    e.q = m_tbl[m_idx]; e.idx = m_idx; e.busy = (m_mode == 1) ? 1 : 0;
    e.wrap = m_wrap; e.laps = m_laps; e.err = m_err;
    sb.push_back(e);
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input bit rst, input bit run, input bit stop, input bit stp,
                     input bit os, input bit we, input int wa, input int wd);
    R            = rst;
    bus.cmd_run  = run;
    bus.cmd_stop = stop;
    bus.cmd_step = stp;
    bus.oneshot  = os;
    bus.wr_en    = we;
    bus.wr_addr  = 3'(wa);
    bus.wr_data  = 4'(wd);
    model(rst, run, stop, stp, os, we, wa, wd);
    @(posedge C);
    #1;
  endtask

  task automatic idle(input int n, input bit os);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, os, 0, 0, 0);
  endtask

  // Monitor: every cycle with a pending expectation is compared on the falling edge.
  always @(negedge C) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("Q",    32'(bus.Q),    32'(e.q));
      chk("idx",  32'(bus.idx),  32'(e.idx));
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("wrap", 32'(bus.wrap), 32'(e.wrap));
      chk("laps", 32'(bus.laps), 32'(e.laps));
      chk("err",  32'(bus.err),  32'(e.err));
    end
  end

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_Q", 32'(bus.Q), 32'd4);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Continuous run: 20 advances -> two laps, then pause and abort
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("run_busy", 32'(bus.busy), 32'd1);
    idle(20, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("cont_laps", 32'(bus.laps), 32'd2);
    chk("abort_Q", 32'(bus.Q), 32'd4);

    // One-shot lap
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0);
    idle(12, 1);
    chk("os_busy", 32'(bus.busy), 32'd0);
    chk("os_laps", 32'(bus.laps), 32'd1);
    chk("os_idx", 32'(bus.idx), 32'd0);

    // Stop / step / resume / abort
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("pause_Q", 32'(bus.Q), 32'd3);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("step_Q", 32'(bus.Q), 32'd12);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    chk("resume_Q", 32'(bus.Q), 32'd11);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);

    // Programming in IDLE, then a rejected write while running
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, i, i);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(10, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 9);
    chk("run_wr_err", 32'(bus.err), 32'd1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("prog_Q0", 32'(bus.Q), 32'd0);

    // Simultaneous commands
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    chk("runstop_idle", 32'(bus.busy), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    chk("stopstep_idx", 32'(bus.idx), 32'd0);

    // Write and step on the same edge: new entry shows at the advanced position
    cyc(0, 0, 0, 1, 0, 1, 1, 15);
    chk("wrstep_Q", 32'(bus.Q), 32'd15);

    // Lap saturation, then reset mid-run
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(260 * 8, 0);
    chk("sat_laps", 32'(bus.laps), 32'd255);
    cyc(0, 0, 0, 0, 0, 1, 0, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_Q", 32'(bus.Q), 32'd4);
    chk("midrst_laps", 32'(bus.laps), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 20,
          1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end

    idle(1, 0);
    @(negedge C);
    #1;
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
